// File: rtl/program_store_if.sv
// Loader / CPU-side bus of the program store: load stream, reload request,
// fetch port and status outputs.
interface program_store_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_ready;
  logic                  reload;
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  fetch_valid;
  logic                  running;
  logic [ADDR_WIDTH:0]   load_count;
  logic                  load_trunc;

  modport master (
    output load_valid, load_data, load_last, reload, fetch_req, fetch_addr,
    input  load_ready, fetch_data, fetch_valid, running, load_count, load_trunc
  );

  modport slave (
    input  load_valid, load_data, load_last, reload, fetch_req, fetch_addr,
    output load_ready, fetch_data, fetch_valid, running, load_count, load_trunc
  );
endinterface

// File: rtl/program_store.sv
// Program memory: zeroes itself after reset (CLEAR), accepts a streamed
// program (LOAD), then serves one-cycle-latency instruction fetches (RUN).
module program_store #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  program_store_if.slave   bus
);

  localparam int unsigned   CW       = ADDR_WIDTH + 1;
  localparam int unsigned   IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         clr_cnt_q, clr_cnt_d;
  logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
  logic                  trunc_q, trunc_d;
  logic                  load_ready_q, load_ready_d;
  logic                  running_q, running_d;
  logic                  fetch_valid_q, fetch_valid_d;
  logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;
  logic [IW-1:0]         mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  accept;
  logic                  in_range;

  // Next-state, memory write port and fetch result
  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    trunc_d       = trunc_q;
    mem_we        = 1'b0;
    mem_waddr     = IW'(0);
    mem_wdata     = '0;
    accept        = bus.load_valid && (state_q == S_LOAD);
    in_range      = {1'b0, bus.fetch_addr} < DEPTH_C;
    fetch_valid_d = 1'b0;
    fetch_data_d  = fetch_data_q;

    unique case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q[IW-1:0];
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = S_LOAD;
          clr_cnt_d = '0;
          wr_ptr_d  = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CW'(1);
        end
      end
      S_LOAD: begin
        if (accept) begin
          mem_we    = 1'b1;
          mem_waddr = wr_ptr_q[IW-1:0];
          mem_wdata = bus.load_data;
          wr_ptr_d  = wr_ptr_q + CW'(1);
          if (bus.load_last) begin
            state_d = S_RUN;
          end else if (wr_ptr_q == LAST_IDX) begin
            trunc_d = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        // Memory is kept: words past the new program retain old contents
        if (bus.reload) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
          trunc_d  = 1'b0;
        end
      end
      default: state_d = S_CLEAR;
    endcase

    load_ready_d = (state_d == S_LOAD);
    running_d    = (state_d == S_RUN);

    if (bus.fetch_req) begin
      if (state_q == S_RUN) begin
        fetch_valid_d = 1'b1;
        fetch_data_d  = in_range ? mem_q[bus.fetch_addr[IW-1:0]] : '0;
      end else begin
        fetch_data_d  = '0;
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_CLEAR;
      clr_cnt_q     <= '0;
      wr_ptr_q      <= '0;
      trunc_q       <= 1'b0;
      load_ready_q  <= 1'b0;
      running_q     <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      trunc_q       <= trunc_d;
      load_ready_q  <= load_ready_d;
      running_q     <= running_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
    end
  end

  // Storage array, no reset: CLEAR zeroes it
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.load_ready  = load_ready_q;
  assign bus.running     = running_q;
  assign bus.load_count  = wr_ptr_q;
  assign bus.load_trunc  = trunc_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_data  = fetch_data_q;

endmodule

// File: tb/tb_program_store.sv
// Randomized self-checking bench for program_store: a default 256-word
// instance and a 4-word instance, both checked against an array model.
module tb_program_store;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] am [256];
  logic [7:0] bm [4];
  int         aptr;

  always #5 clk = ~clk;

  program_store_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus_a ();
  program_store_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_b ();

  program_store #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) u_big (
    .clk(clk), .reset(rst_a), .bus(bus_a)
  );

  program_store #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(4)) u_small (
    .clk(clk), .reset(rst_b), .bus(bus_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.load_valid = 1'b0; bus_a.load_data = '0; bus_a.load_last = 1'b0;
    bus_a.reload = 1'b0; bus_a.fetch_req = 1'b0; bus_a.fetch_addr = '0;
    bus_b.load_valid = 1'b0; bus_b.load_data = '0; bus_b.load_last = 1'b0;
    bus_b.reload = 1'b0; bus_b.fetch_req = 1'b0; bus_b.fetch_addr = '0;
  endtask

  // Offer one word on the big instance and record it in the model
  task automatic load_a(input logic [7:0] w, input bit last);
    bus_a.load_valid = 1'b1;
    bus_a.load_data  = w;
    bus_a.load_last  = last;
    step();
    bus_a.load_valid = 1'b0;
    bus_a.load_last  = 1'b0;
    am[aptr] = w;
    aptr++;
  endtask

  task automatic fetch(input bit sel, input logic [7:0] addr,
                       output logic [7:0] data, output logic valid);
    if (!sel) begin
      bus_a.fetch_req = 1'b1; bus_a.fetch_addr = addr;
    end else begin
      bus_b.fetch_req = 1'b1; bus_b.fetch_addr = addr[3:0];
    end
    step();
    data  = sel ? bus_b.fetch_data : bus_a.fetch_data;
    valid = sel ? bus_b.fetch_valid : bus_a.fetch_valid;
    bus_a.fetch_req = 1'b0;
    bus_b.fetch_req = 1'b0;
  endtask

  task automatic reload_a();
    bus_a.reload = 1'b1;
    step();
    bus_a.reload = 1'b0;
    aptr = 0;
  endtask

  task automatic wait_clear_a(output int n);
    n = 0;
    while (!bus_a.load_ready && n < 1000) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    logic [7:0] d;
    logic v;
    rst_a = 1'b1;
    step(); step();
    checks++;
    if ({bus_a.running, bus_a.load_ready, bus_a.load_trunc, bus_a.fetch_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000",
               {bus_a.running, bus_a.load_ready, bus_a.load_trunc, bus_a.fetch_valid});
    end
    checks++;
    if (bus_a.load_count !== 9'd0 || bus_a.fetch_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_values got cnt=%0d data=%h exp 0/00", bus_a.load_count, bus_a.fetch_data);
    end
    rst_a = 1'b0;
    wait_clear_a(n);
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL clear_latency got %0d exp 256", n);
    end
    foreach (am[i]) am[i] = 8'h00;
    aptr = 0;
    load_a(8'h00, 1'b1);
    checks++;
    if (bus_a.running !== 1'b1 || bus_a.load_count !== 9'd1) begin
      errors++;
      $display("FAIL empty_prog got run=%b cnt=%0d exp 1/1", bus_a.running, bus_a.load_count);
    end
    fetch(1'b0, 8'h10, d, v);
    checks++;
    if (v !== 1'b1 || d !== am[16]) begin
      errors++;
      $display("FAIL fetch_empty got v=%b d=%h exp 1/%h", v, d, am[16]);
    end
  endtask

  task automatic test_load_program();
    logic [7:0] prog [5] = '{8'hB1, 8'h0A, 8'h82, 8'h44, 8'h9E};
    logic [7:0] d;
    logic v;
    reload_a();
    checks++;
    if (bus_a.load_ready !== 1'b1 || bus_a.running !== 1'b0 || bus_a.load_count !== 9'd0) begin
      errors++;
      $display("FAIL reload_entry got rdy=%b run=%b cnt=%0d exp 1/0/0",
               bus_a.load_ready, bus_a.running, bus_a.load_count);
    end
    for (int i = 0; i < 5; i++) load_a(prog[i], i == 4);
    checks++;
    if (bus_a.running !== 1'b1 || bus_a.load_count !== 9'd5 || bus_a.load_trunc !== 1'b0) begin
      errors++;
      $display("FAIL prog_loaded got run=%b cnt=%0d trunc=%b exp 1/5/0",
               bus_a.running, bus_a.load_count, bus_a.load_trunc);
    end
    for (int a = 0; a < 6; a++) begin
      fetch(1'b0, 8'(a), d, v);
      checks++;
      if (v !== 1'b1 || d !== am[a]) begin
        errors++;
        $display("FAIL prog_fetch[%0d] got v=%b d=%h exp 1/%h", a, v, d, am[a]);
      end
    end
  endtask

  task automatic test_reload_overlap();
    logic [7:0] d;
    logic v;
    bus_a.reload = 1'b1;
    bus_a.fetch_req = 1'b1;
    bus_a.fetch_addr = 8'd2;
    step();
    bus_a.reload = 1'b0;
    bus_a.fetch_req = 1'b0;
    aptr = 0;
    checks++;
    if (bus_a.fetch_valid !== 1'b1 || bus_a.fetch_data !== am[2] || bus_a.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_fetch got v=%b d=%h rdy=%b exp 1/%h/1",
               bus_a.fetch_valid, bus_a.fetch_data, bus_a.load_ready, am[2]);
    end
    load_a(8'h11, 1'b0);
    load_a(8'h22, 1'b1);
    checks++;
    if (bus_a.load_count !== 9'd2 || bus_a.running !== 1'b1) begin
      errors++;
      $display("FAIL reload_count got cnt=%0d run=%b exp 2/1", bus_a.load_count, bus_a.running);
    end
    for (int a = 0; a < 3; a++) begin
      fetch(1'b0, 8'(a), d, v);
      checks++;
      if (v !== 1'b1 || d !== am[a]) begin
        errors++;
        $display("FAIL reload_fetch[%0d] got v=%b d=%h exp 1/%h", a, v, d, am[a]);
      end
    end
  endtask

  task automatic test_stall();
    int n_words;
    int i;
    int cyc;
    reload_a();
    n_words = 4 + int'($urandom_range(0, 4));
    i = 0;
    cyc = 0;
    while (i < n_words && cyc < 200) begin
      cyc++;
      if ($urandom_range(0, 1) == 0) begin
        bus_a.load_valid = 1'b0;
        bus_a.load_last  = 1'($urandom_range(0, 1));
        bus_a.fetch_req  = 1'b1;
        bus_a.fetch_addr = 8'($urandom);
        step();
        bus_a.fetch_req = 1'b0;
        bus_a.load_last = 1'b0;
        checks++;
        if (bus_a.fetch_valid !== 1'b0 || bus_a.fetch_data !== 8'h00 ||
            bus_a.load_count !== 9'(aptr) || bus_a.running !== 1'b0) begin
          errors++;
          $display("FAIL stall_bubble got v=%b d=%h cnt=%0d run=%b exp 0/00/%0d/0",
                   bus_a.fetch_valid, bus_a.fetch_data, bus_a.load_count, bus_a.running, aptr);
        end
      end else begin
        load_a(8'($urandom), i == n_words - 1);
        i++;
        checks++;
        if (bus_a.load_count !== 9'(aptr)) begin
          errors++;
          $display("FAIL stall_accept got cnt=%0d exp %0d", bus_a.load_count, aptr);
        end
      end
    end
    checks++;
    if (bus_a.running !== 1'b1 || i !== n_words) begin
      errors++;
      $display("FAIL stall_done got run=%b words=%0d exp 1/%0d", bus_a.running, i, n_words);
    end
  endtask

  task automatic test_random_fetch();
    logic [7:0] d, last_d, addr;
    logic v;
    fetch(1'b0, 8'd0, last_d, v);
    for (int i = 0; i < 40; i++) begin
      addr = (i % 2 == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        fetch(1'b0, addr, d, v);
        checks++;
        if (v !== 1'b1 || d !== am[addr]) begin
          errors++;
          $display("FAIL rand_fetch[%0d] got v=%b d=%h exp 1/%h", addr, v, d, am[addr]);
        end
        last_d = am[addr];
      end else begin
        bus_a.fetch_addr = addr;
        step();
        checks++;
        if (bus_a.fetch_valid !== 1'b0 || bus_a.fetch_data !== last_d) begin
          errors++;
          $display("FAIL rand_hold got v=%b d=%h exp 0/%h", bus_a.fetch_valid, bus_a.fetch_data, last_d);
        end
      end
    end
  endtask

  task automatic test_trunc();
    int n;
    logic [7:0] w, d;
    logic v;
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    n = 0;
    while (!bus_b.load_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL small_clear got %0d exp 4", n);
    end
    foreach (bm[k]) bm[k] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      w = 8'($urandom);
      bus_b.load_valid = 1'b1;
      bus_b.load_data  = w;
      bus_b.load_last  = 1'b0;
      step();
      if (i < 4) bm[i] = w;
    end
    bus_b.load_valid = 1'b0;
    checks++;
    if (bus_b.load_count !== 5'd4 || bus_b.load_trunc !== 1'b1 || bus_b.running !== 1'b1) begin
      errors++;
      $display("FAIL trunc_state got cnt=%0d trunc=%b run=%b exp 4/1/1",
               bus_b.load_count, bus_b.load_trunc, bus_b.running);
    end
    fetch(1'b1, 8'd9, d, v);
    checks++;
    if (v !== 1'b1 || d !== 8'h00) begin
      errors++;
      $display("FAIL trunc_oob got v=%b d=%h exp 1/00", v, d);
    end
    for (int a = 0; a < 4; a++) begin
      fetch(1'b1, 8'(a), d, v);
      checks++;
      if (v !== 1'b1 || d !== bm[a]) begin
        errors++;
        $display("FAIL trunc_fetch[%0d] got v=%b d=%h exp 1/%h", a, v, d, bm[a]);
      end
    end
    bus_b.reload = 1'b1;
    step();
    bus_b.reload = 1'b0;
    checks++;
    if (bus_b.load_trunc !== 1'b0 || bus_b.load_ready !== 1'b1 || bus_b.load_count !== 5'd0) begin
      errors++;
      $display("FAIL trunc_reload got trunc=%b rdy=%b cnt=%0d exp 0/1/0",
               bus_b.load_trunc, bus_b.load_ready, bus_b.load_count);
    end
    w = 8'($urandom);
    bus_b.load_valid = 1'b1;
    bus_b.load_data  = w;
    bus_b.load_last  = 1'b1;
    step();
    bus_b.load_valid = 1'b0;
    bus_b.load_last  = 1'b0;
    bm[0] = w;
    fetch(1'b1, 8'd1, d, v);
    checks++;
    if (v !== 1'b1 || d !== bm[1] || bus_b.load_count !== 5'd1 || bus_b.load_trunc !== 1'b0) begin
      errors++;
      $display("FAIL trunc_keep got v=%b d=%h cnt=%0d trunc=%b exp 1/%h/1/0",
               v, d, bus_b.load_count, bus_b.load_trunc, bm[1]);
    end
  endtask

  task automatic test_reset_mid_load();
    int n;
    logic [7:0] d;
    logic v;
    reload_a();
    load_a(8'hC3, 1'b0);
    load_a(8'h3C, 1'b0);
    bus_a.load_valid = 1'b1;
    bus_a.load_data  = 8'h77;
    rst_a = 1'b1;
    step();
    bus_a.load_valid = 1'b0;
    checks++;
    if ({bus_a.running, bus_a.load_ready, bus_a.load_trunc, bus_a.fetch_valid} !== 4'b0000 ||
        bus_a.load_count !== 9'd0 || bus_a.fetch_data !== 8'h00) begin
      errors++;
      $display("FAIL midload_reset got flags=%b cnt=%0d d=%h exp 0000/0/00",
               {bus_a.running, bus_a.load_ready, bus_a.load_trunc, bus_a.fetch_valid},
               bus_a.load_count, bus_a.fetch_data);
    end
    rst_a = 1'b0;
    foreach (am[i]) am[i] = 8'h00;
    aptr = 0;
    wait_clear_a(n);
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL midload_clear got %0d exp 256", n);
    end
    load_a(8'h5A, 1'b1);
    for (int a = 0; a < 3; a++) begin
      fetch(1'b0, 8'(a), d, v);
      checks++;
      if (v !== 1'b1 || d !== am[a]) begin
        errors++;
        $display("FAIL midload_fetch[%0d] got v=%b d=%h exp 1/%h", a, v, d, am[a]);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_program();
    test_reload_overlap();
    test_stall();
    test_random_fetch();
    test_trunc();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_store.md
PROGRAM_STORE -- requirements
Module: program_store

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, instruction word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, fetch/load address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 2**ADDR_WIDTH, number of stored words; legal range 2..2**ADDR_WIDTH.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 load_valid  input  1  loader offers load_data this cycle.
REQ-008 load_data  input  DATA_WIDTH  program word to store.
REQ-009 load_last  input  1  qualifies load_valid; offered word is the final program word.
REQ-010 load_ready  output  1  block accepts a load word this cycle.
REQ-011 reload  input  1  single-cycle request to re-enter LOAD from RUN.
REQ-012 fetch_req  input  1  CPU requests the word at fetch_addr.
REQ-013 fetch_addr  input  ADDR_WIDTH  fetch address.
REQ-014 fetch_data  output  DATA_WIDTH  registered fetch result.
REQ-015 fetch_valid  output  1  fetch_data holds the result of the previous cycle's request.
REQ-016 running  output  1  high only in RUN.
REQ-017 load_count  output  ADDR_WIDTH+1  words accepted in the current/last load session.
REQ-018 load_trunc  output  1  sticky; the load filled DEPTH words without load_last.

Function
REQ-019 The FSM SHALL have states CLEAR, LOAD, RUN; reset SHALL force CLEAR.
REQ-020 CLEAR SHALL write 0 to one word per cycle at addresses 0..DEPTH-1 in order, taking exactly DEPTH cycles, then go to LOAD.
REQ-021 load_ready SHALL be 1 only in LOAD; a word is accepted when load_valid && load_ready.
REQ-022 Accepted words SHALL be written at an internal write pointer that starts at 0 on LOAD entry and increments by 1 per accepted word.
REQ-023 load_count SHALL equal the write pointer value; it SHALL reset to 0 on LOAD entry and hold its value in RUN.
REQ-024 Accepting a word with load_last=1 SHALL write it and move to RUN the next cycle; load_trunc unchanged.
REQ-025 Accepting a word at address DEPTH-1 with load_last=0 SHALL write it, set load_trunc, and move to RUN.
REQ-026 load_last without load_valid SHALL be ignored.
REQ-027 In RUN, reload=1 SHALL move to LOAD next cycle without clearing memory; load_trunc SHALL clear on that transition; words beyond the new load keep old contents.
REQ-028 reload outside RUN SHALL be ignored.
REQ-029 Fetch latency SHALL be exactly one cycle: fetch_req=1 in RUN at edge N gives fetch_data and fetch_valid=1 after edge N+1's register update, i.e. valid in cycle N+1.
REQ-030 fetch_addr >= DEPTH SHALL return fetch_data=0 with fetch_valid=1.
REQ-031 fetch_req outside RUN SHALL give fetch_valid=0 and fetch_data=0 next cycle.
REQ-032 fetch_req=0 SHALL give fetch_valid=0 next cycle; fetch_data SHALL hold its previous value.
REQ-033 A fetch in the same cycle as reload SHALL still be served (state is RUN that cycle).
REQ-034 Writes and reads SHALL never target memory in the same cycle (LOAD/CLEAR vs RUN exclusive); no read-during-write rule is needed.
REQ-035 The write pointer and CLEAR counter SHALL never wrap; terminal count ends the state.

Reset
REQ-036 On reset: state CLEAR, fetch_data=0, fetch_valid=0, running=0, load_ready=0, load_count=0, load_trunc=0, pointers 0.
REQ-037 Reset asserted mid-LOAD or mid-RUN SHALL abort immediately and restart CLEAR; memory contents after reset SHALL be all zero once CLEAR completes.
REQ-038 Memory contents SHALL NOT be relied on before CLEAR completes.

Verification
REQ-039 Defaults, reset then idle: load_ready rises exactly 256 cycles after reset release; fetch after loading empty program (single word 0x00 with last) of addr 0x10 -> 0x00.
REQ-040 Load 0xB1,0x0A,0x82,0x44,0x9E with last on 0x9E -> running=1, load_count=5; fetch 0..5 -> 0xB1,0x0A,0x82,0x44,0x9E,0x00, each one cycle after request.
REQ-041 DEPTH=4, ADDR_WIDTH=4: load 5 words without last -> 4 accepted, load_trunc=1, running=1; fetch addr 9 -> 0x00, fetch_valid=1.
REQ-042 In RUN after REQ-040, reload, load 0x11,0x22 with last -> addr 0,1 = 0x11,0x22; addr 2 = 0x82; load_count=2.
REQ-043 Stalled loader: load_valid toggling 1/0 with bubbles -> only valid cycles advance load_count; fetch_req during LOAD -> fetch_valid=0.
REQ-044 Reset asserted on third accepted load word -> state CLEAR, all outputs at reset values next cycle; after new CLEAR, fetch of previously loaded addr 0 (post-load) returns new content only.
